// File: rtl/rom_scan_ctrl.sv
// rom_scan_ctrl: reads a burst of words from an 8x8 ROM and hands each
// word downstream over a valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   start      burst request, sampled only in IDLE
//   base_addr  first ROM address of the burst
//   count      words to read (0 = no burst, values above 8 clamp to 8)
//   rom_data   word returned by the ROM for addr
//   out_ready  downstream accepts out_data
//   addr       registered ROM address
//   CS         ROM chip select, active-low
//   out_data   captured ROM word
//   out_valid  out_data is valid
//   busy       FSM is not idle
//   done       one-cycle pulse after the last word is accepted
//   checksum   XOR of the words accepted in this burst
//              (present only when ROM_SCAN_CHECKSUM_EN is defined)
//
// Optional feature macro: ROM_SCAN_CHECKSUM_EN

module rom_scan_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] base_addr,
    input  logic [3:0] count,
    input  logic [7:0] rom_data,
    input  logic       out_ready,
    output logic [2:0] addr,
    output logic       CS,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       busy,
`ifdef ROM_SCAN_CHECKSUM_EN
    output logic [7:0] checksum,
`endif
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] addr_q, addr_d;
    logic [3:0] rem_q, rem_d;
    logic [7:0] data_q, data_d;

    logic accept;
    logic hshake;

    assign accept = (state_q == IDLE) && start && (count != 4'd0);
    assign hshake = (state_q == SEND) && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= 3'd0;
            rem_q   <= 4'd0;
            data_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        data_d    = data_q;
        CS        = 1'b1;
        out_valid = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;

        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (accept) begin
                    addr_d  = base_addr;
                    rem_d   = (count > 4'd8) ? 4'd8 : count;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                CS      = 1'b0;
                data_d  = rom_data;
                state_d = SEND;
            end
            SEND: begin
                CS        = 1'b0;
                out_valid = 1'b1;
                if (hshake) begin
                    if (rem_q == 4'd1) begin
                        rem_d   = 4'd0;
                        state_d = DONE;
                    end else begin
                        // 3-bit add wraps 7 -> 0 naturally
                        rem_d   = rem_q - 4'd1;
                        addr_d  = addr_q + 3'd1;
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign addr     = addr_q;
    assign out_data = data_q;

`ifdef ROM_SCAN_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (accept) begin
            csum_d = 8'd0;
        end else if (hshake) begin
            csum_d = csum_q ^ data_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_q <= 8'd0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_rom_scan_ctrl.sv
// tb_rom_scan_ctrl: directed bench for rom_scan_ctrl with a behavioural
// 8x8 ROM attached to addr/CS.

module tb_rom_scan_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] base_addr;
    logic [3:0] count;
    logic [7:0] rom_data;
    logic       out_ready;
    logic [2:0] addr;
    logic       CS;
    logic [7:0] out_data;
    logic       out_valid;
    logic       busy;
    logic       done;
`ifdef ROM_SCAN_CHECKSUM_EN
    logic [7:0] checksum;
`endif

    int n_chk;
    int n_fail;

    logic [7:0] rom [0:7];

    rom_scan_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .rom_data  (rom_data),
        .out_ready (out_ready),
        .addr      (addr),
        .CS        (CS),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy),
`ifdef ROM_SCAN_CHECKSUM_EN
        .checksum  (checksum),
`endif
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rom_data = rom[addr];

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Runs one burst with out_ready held high. Expects n words, done
    // visible 2n edges after the accept edge, and a given checksum.
    task automatic run_burst(input int b, input int c, input int n,
                             input bit poke, input logic [7:0] exp_cs);
        int cyc;
        int idx;
        int done_cyc;
        int a;
        out_ready = 1'b1;
        start     = 1'b1;
        base_addr = 3'(b);
        count     = 4'(c);
        tick();
        start     = 1'b0;
        cyc       = 0;
        idx       = 0;
        done_cyc  = -1;
        for (int k = 0; k < 40; k++) begin
            tick();
            cyc++;
            if (poke && cyc == 2) begin
                start     = 1'b1;
                base_addr = 3'd5;
                count     = 4'd1;
            end else begin
                start = 1'b0;
            end
            if (out_valid) begin
                a = (b + idx) % 8;
                check("word_addr", 32'(addr), 32'(a));
                check("word_data", 32'(out_data), 32'(rom[a]));
                idx++;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        start = 1'b0;
        if (done_cyc < 0) check("done_timeout", 32'd0, 32'd1);
        check("word_count", 32'(idx), 32'(n));
        check("done_latency", 32'(done_cyc), 32'(2 * n));
        check("done_cs", 32'(CS), 32'd1);
        check("done_busy", 32'(busy), 32'd1);
`ifdef ROM_SCAN_CHECKSUM_EN
        check("checksum", 32'(checksum), 32'(exp_cs));
`else
        if (exp_cs === 8'hxx) check("cs_arg", 32'd0, 32'd1);
`endif
        tick();
        check("done_pulse_end", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
`ifdef ROM_SCAN_CHECKSUM_EN
        check("checksum_hold", 32'(checksum), 32'(exp_cs));
`endif
    endtask

    initial begin
        rom[0] = 8'h46; rom[1] = 8'h50; rom[2] = 8'h67; rom[3] = 8'h71;
        rom[4] = 8'h92; rom[5] = 8'hB0; rom[6] = 8'hD1; rom[7] = 8'hFF;
        n_chk     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = 3'd0;
        count     = 4'd0;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_cs", 32'(CS), 32'd1);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        tick();

        // full ROM scan
        run_burst(0, 8, 8, 1'b0, 8'h0C);
        check("idle_keep_addr", 32'(addr), 32'd7);
        check("idle_keep_data", 32'(out_data), 32'hFF);

        // address wrap
        run_burst(6, 4, 4, 1'b0, 8'h38);

        // back-pressure on a single word
        out_ready = 1'b0;
        start     = 1'b1;
        base_addr = 3'd3;
        count     = 4'd1;
        tick();
        start = 1'b0;
        check("stall_fetch_cs", 32'(CS), 32'd0);
        check("stall_fetch_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", 32'(out_data), 32'h71);
            check("stall_addr", 32'(addr), 32'd3);
            check("stall_done", 32'(done), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("stall_done_pulse", 32'(done), 32'd1);
        check("stall_valid_off", 32'(out_valid), 32'd0);
`ifdef ROM_SCAN_CHECKSUM_EN
        check("stall_checksum", 32'(checksum), 32'h71);
`endif
        tick();
        check("stall_done_end", 32'(done), 32'd0);

        // count = 0 is ignored
        start     = 1'b1;
        base_addr = 3'd2;
        count     = 4'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("zero_busy", 32'(busy), 32'd0);
            check("zero_cs", 32'(CS), 32'd1);
            check("zero_done", 32'(done), 32'd0);
        end
        start = 1'b0;
        tick();

        // count above 8 clamps
        run_burst(0, 12, 8, 1'b0, 8'h0C);

        // start during a burst is ignored
        run_burst(2, 3, 3, 1'b1, 8'h67 ^ 8'h71 ^ 8'h92);

        // reset while in SEND
        start     = 1'b1;
        base_addr = 3'd4;
        count     = 4'd4;
        tick();
        start = 1'b0;
        tick();
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        check("pre_rst_data", 32'(out_data), 32'h92);
        rst = 1'b1;
        #1;
        check("arst_addr", 32'(addr), 32'd0);
        check("arst_cs", 32'(CS), 32'd1);
        check("arst_data", 32'(out_data), 32'd0);
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
`ifdef ROM_SCAN_CHECKSUM_EN
        check("arst_checksum", 32'(checksum), 32'd0);
`endif
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_busy", 32'(busy), 32'd0);
            check("post_rst_done", 32'(done), 32'd0);
        end

        // clean burst after reset
        run_burst(1, 2, 2, 1'b0, 8'h50 ^ 8'h67);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
